// File: rtl/iddmm_arbiter.sv
// Round-robin front end that shares one iddmm_top Montgomery engine between two requesters.
// Define IDDMM_ARB_TIMEOUT_EN to add a result watchdog that aborts stalled jobs with res_err.
module iddmm_arbiter #(
  parameter int unsigned K       = 128,
  parameter int unsigned N       = 32,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  output logic [1:0]        gnt,
  input  logic [1:0]        ld_valid,
  input  logic [2*K-1:0]    ld_x,
  input  logic [2*K-1:0]    ld_y,
  input  logic [2*K-1:0]    ld_m,
  input  logic [2*K-1:0]    ld_m1,
  output logic              ld_ready,
  output logic [2:0]        wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [K-1:0]      wr_x,
  output logic [K-1:0]      wr_y,
  output logic [K-1:0]      wr_m,
  output logic [K-1:0]      wr_m1,
  output logic              task_req,
  input  logic              task_grant,
  input  logic [K-1:0]      task_res,
  output logic              res_valid,
  output logic [K-1:0]      res_data,
  output logic              res_last,
  output logic              res_id,
  output logic              res_err
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] rcnt_q, rcnt_d;
  logic              ld_ready_q, ld_ready_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_x_q, wr_x_d;
  logic [K-1:0]      wr_y_q, wr_y_d;
  logic [K-1:0]      wr_m_q, wr_m_d;
  logic [K-1:0]      wr_m1_q, wr_m1_d;
  logic              task_req_q, task_req_d;
  logic              res_valid_q, res_valid_d;
  logic [K-1:0]      res_data_q, res_data_d;
  logic              res_last_q, res_last_d;
  logic              res_id_q, res_id_d;
  logic              win;

`ifdef IDDMM_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic          res_err_q, res_err_d;
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Operand slice of the requester that currently owns the engine.
  logic [K-1:0] sel_x, sel_y, sel_m, sel_m1;
  logic         sel_valid;

  assign sel_x     = owner_q ? ld_x[2*K-1:K]  : ld_x[K-1:0];
  assign sel_y     = owner_q ? ld_y[2*K-1:K]  : ld_y[K-1:0];
  assign sel_m     = owner_q ? ld_m[2*K-1:K]  : ld_m[K-1:0];
  assign sel_m1    = owner_q ? ld_m1[2*K-1:K] : ld_m1[K-1:0];
  assign sel_valid = owner_q ? ld_valid[1]    : ld_valid[0];

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    ld_ready_d  = 1'b0;
    wr_ena_d    = 3'b000;
    wr_addr_d   = wr_addr_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    wr_m_d      = wr_m_q;
    wr_m1_d     = wr_m1_q;
    task_req_d  = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_last_d  = 1'b0;
    res_id_d    = res_id_q;
    win         = ~last_q;
`ifdef IDDMM_ARB_TIMEOUT_EN
    res_err_d   = 1'b0;
    tmo_d       = tmo_q;
`endif

    case (state_q)
      S_IDLE: begin
        // A tie goes to the requester not served last; a lone request wins outright.
        win = (req == 2'b11) ? ~last_q : req[1];
        if (req != 2'b00) begin
          owner_d    = win;
          gnt_d      = win ? 2'b10 : 2'b01;
          wcnt_d     = '0;
          ld_ready_d = 1'b1;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        ld_ready_d = 1'b1;
        if (sel_valid) begin
          wr_ena_d  = 3'b111;
          wr_addr_d = wcnt_q;
          wr_x_d    = sel_x;
          wr_y_d    = sel_y;
          wr_m_d    = sel_m;
          wr_m1_d   = sel_m1;
          wcnt_d    = wcnt_q + ADDR_W'(1);
          if (wcnt_q == LAST_WORD) begin
            ld_ready_d = 1'b0;
            state_d    = S_START;
          end
        end
      end

      S_START: begin
        task_req_d = 1'b1;
        rcnt_d     = '0;
`ifdef IDDMM_ARB_TIMEOUT_EN
        tmo_d      = '0;
`endif
        state_d    = S_WAIT;
      end

      S_WAIT, S_DRAIN: begin
        // A paused engine simply leaves the result counter where it is.
        if (task_grant) begin
          res_valid_d = 1'b1;
          res_data_d  = task_res;
          res_id_d    = owner_q;
          rcnt_d      = rcnt_q + ADDR_W'(1);
          state_d     = S_DRAIN;
          if (rcnt_q == LAST_WORD) begin
            res_last_d = 1'b1;
            gnt_d      = 2'b00;
            last_d     = owner_q;
            state_d    = S_IDLE;
          end
        end
`ifdef IDDMM_ARB_TIMEOUT_EN
        tmo_d = tmo_q + TW'(1);
        // Abort unless this very cycle completes the job normally.
        if (tmo_q == TW'(TIMEOUT - 1) && state_d != S_IDLE) begin
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_last_d  = 1'b1;
          res_data_d  = '0;
          res_id_d    = owner_q;
          gnt_d       = 2'b00;
          last_d      = owner_q;
          state_d     = S_IDLE;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      ld_ready_q  <= 1'b0;
      wr_ena_q    <= 3'b000;
      wr_addr_q   <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_m_q      <= '0;
      wr_m1_q     <= '0;
      task_req_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      res_id_q    <= 1'b0;
`ifdef IDDMM_ARB_TIMEOUT_EN
      res_err_q   <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      ld_ready_q  <= ld_ready_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_m_q      <= wr_m_d;
      wr_m1_q     <= wr_m1_d;
      task_req_q  <= task_req_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      res_id_q    <= res_id_d;
`ifdef IDDMM_ARB_TIMEOUT_EN
      res_err_q   <= res_err_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign ld_ready  = ld_ready_q;
  assign wr_ena    = wr_ena_q;
  assign wr_addr   = wr_addr_q;
  assign wr_x      = wr_x_q;
  assign wr_y      = wr_y_q;
  assign wr_m      = wr_m_q;
  assign wr_m1     = wr_m1_q;
  assign task_req  = task_req_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_last  = res_last_q;
  assign res_id    = res_id_q;
`ifdef IDDMM_ARB_TIMEOUT_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_iddmm_arbiter.sv
// Scoreboard bench for iddmm_arbiter: random operands, engine model, grant/write/result checks.
`timescale 1ns/1ps
module tb_iddmm_arbiter;

  localparam int unsigned K  = 128;
  localparam int unsigned N  = 32;
  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = 4 * K;
`ifdef IDDMM_ARB_TIMEOUT_EN
  localparam int unsigned TMO = 100;
`else
  localparam int unsigned TMO = 4096;
`endif

  typedef struct packed { logic [K-1:0] x; logic [K-1:0] y; logic [K-1:0] m; logic [K-1:0] m1; } ops_t;
  typedef struct packed { logic [AW-1:0] addr; ops_t d; } wr_t;
  typedef struct packed { logic [K-1:0] data; logic id; logic last; logic err; } res_t;
  typedef struct packed { int unsigned load_cyc; int unsigned span; logic silent; } job_t;

  logic            clk, rst_n;
  logic [1:0]      req, gnt, ld_valid;
  logic [2*K-1:0]  ld_x, ld_y, ld_m, ld_m1;
  logic            ld_ready;
  logic [2:0]      wr_ena;
  logic [AW-1:0]   wr_addr;
  logic [K-1:0]    wr_x, wr_y, wr_m, wr_m1;
  logic            task_req, task_grant;
  logic [K-1:0]    task_res;
  logic            res_valid, res_last, res_id, res_err;
  logic [K-1:0]    res_data;

  logic            rq [2];
  logic            lv [2];
  logic [K-1:0]    lx [2], ly [2], lm [2], lm1 [2];

  assign req      = {rq[1], rq[0]};
  assign ld_valid = {lv[1], lv[0]};
  assign ld_x     = {lx[1], lx[0]};
  assign ld_y     = {ly[1], ly[0]};
  assign ld_m     = {lm[1], lm[0]};
  assign ld_m1    = {lm1[1], lm1[0]};

  iddmm_arbiter #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .ld_valid(ld_valid),
    .ld_x(ld_x), .ld_y(ld_y), .ld_m(ld_m), .ld_m1(ld_m1), .ld_ready(ld_ready),
    .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_x(wr_x), .wr_y(wr_y), .wr_m(wr_m), .wr_m1(wr_m1),
    .task_req(task_req), .task_grant(task_grant), .task_res(task_res),
    .res_valid(res_valid), .res_data(res_data), .res_last(res_last), .res_id(res_id), .res_err(res_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned jobs    = 0;
  int unsigned treq_total = 0;
  int unsigned gnt_bad = 0;
  bit          mlast;
  bit          silent = 1'b0;
  int          pause_at = -1;
  int          pause_len = 0;

  wr_t  exp_wr [$];
  res_t exp_res [$];
  job_t exp_job [$];
  bit   exp_gnt [$];

  task automatic chk(input string nm, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [K-1:0] rk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Engine's arithmetic stand-in: any operand mix-up changes the result.
  function automatic logic [K-1:0] eng_f(input ops_t o);
    return (o.x + o.y) ^ o.m ^ {o.m1[K-2:0], o.m1[K-1]};
  endfunction

  // Round-robin rule: a lone request wins, a tie goes to the one not served last.
  function automatic bit pick(input logic [1:0] m, input bit last);
    if (m == 2'b11) return ~last;
    return m[1];
  endfunction

  // Engine model: operand RAM fed by the write port, results streamed after task_req.
  ops_t eram [N];
  always @(posedge clk) if (wr_ena == 3'b111) eram[wr_addr] <= {wr_x, wr_y, wr_m, wr_m1};

  initial begin
    task_grant = 1'b0;
    task_res   = '0;
    forever begin
      @(negedge clk);
      if (task_req === 1'b1 && !silent) begin
        for (int w = 0; w < int'(N); w++) begin
          task_grant = 1'b1;
          task_res   = eng_f(eram[w]);
          @(negedge clk);
          task_grant = 1'b0;
          if (w == pause_at) repeat (pause_len) @(negedge clk);
        end
      end
    end
  end

  // Requester model: request, wait for grant, then feed N words.
  task automatic run_job(input int i, input bit gap, input bit noise);
    ops_t        o [N];
    int unsigned to;
    int          idx, cyc;
    bit          v, rdy;
    wr_t         we;
    res_t        re;
    job_t        je;
    for (int w = 0; w < int'(N); w++) o[w] = {rk(), rk(), rk(), rk()};
    @(negedge clk);
    rq[i] = 1'b1;
    to = 0;
    while (gnt[i] !== 1'b1 && to < 3000) begin
      if (noise) begin
        lv[i] = 1'b1; lx[i] = rk(); ly[i] = rk(); lm[i] = rk(); lm1[i] = rk();
      end
      @(negedge clk);
      to++;
    end
    rq[i] = 1'b0;
    lv[i] = 1'b0;
    if (gnt[i] !== 1'b1) begin
      chk("grant_wait", CW'(gnt[i]), CW'(1));
      return;
    end
    jobs++;
    for (int w = 0; w < int'(N); w++) begin
      we.addr = AW'(w);
      we.d    = o[w];
      exp_wr.push_back(we);
    end
    if (silent) begin
      re.data = '0; re.id = i[0]; re.last = 1'b1; re.err = 1'b1;
      exp_res.push_back(re);
    end else begin
      for (int w = 0; w < int'(N); w++) begin
        re.data = eng_f(o[w]); re.id = i[0]; re.last = (w == int'(N) - 1); re.err = 1'b0;
        exp_res.push_back(re);
      end
    end
    je.load_cyc = gap ? 2 * N : N;
    je.span     = silent ? TMO
                : N + ((pause_at >= 0 && pause_at < int'(N) - 1) ? pause_len : 0);
    je.silent   = silent;
    exp_job.push_back(je);
    idx = 0;
    cyc = 0;
    while (idx < int'(N) && cyc < 4 * int'(N)) begin
      v     = gap ? cyc[0] : 1'b1;
      lv[i] = v;
      lx[i] = o[idx].x; ly[i] = o[idx].y; lm[i] = o[idx].m; lm1[i] = o[idx].m1;
      rdy   = (ld_ready === 1'b1) && (gnt[i] === 1'b1);
      @(negedge clk);
      if (v && rdy) idx++;
      cyc++;
    end
    lv[i] = 1'b0;
    if (idx < int'(N)) chk("load_wait", CW'(idx), CW'(N));
  endtask

  task automatic wait_idle(input int unsigned bound);
    int unsigned t = 0;
    while ((exp_res.size() != 0 || exp_job.size() != 0) && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("job_drain", CW'(exp_res.size()), CW'(0));
    exp_res.delete();
    exp_job.delete();
    exp_wr.delete();
    exp_gnt.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic scen(input logic [1:0] m, input bit g0, input bit g1, input bit nz1, input int dly);
    bit first;
    if (m == 2'b11) begin
      first = (dly > 0) ? 1'b0 : pick(m, mlast);
      exp_gnt.push_back(first);
      exp_gnt.push_back(~first);
      mlast = ~first;
    end else begin
      exp_gnt.push_back(pick(m, mlast));
      mlast = pick(m, mlast);
    end
    fork
      begin if (m[0]) run_job(0, g0, 1'b0); end
      begin if (m[1]) begin repeat (dly) @(negedge clk); run_job(1, g1, nz1); end end
    join
    wait_idle(2000);
  endtask

  // Output monitor: grants, engine writes, result words and per-job timing.
  int unsigned cyc_n = 0, ldc = 0, treq_n = 0, treq_cyc = 0, first_cyc = 0;
  bit          in_res = 1'b0;
  logic [1:0]  gnt_prev = 2'b00;

  initial begin
    wr_t  ew;
    res_t er;
    job_t ej;
    bit   eg;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (rst_n !== 1'b0) begin
        gnt_prev = 2'b00;
        continue;
      end
      if (gnt == 2'b11 || (gnt_prev != 2'b00 && gnt != 2'b00 && gnt != gnt_prev)) gnt_bad++;
      if (gnt_prev == 2'b00 && gnt != 2'b00) begin
        if (exp_gnt.size() == 0) chk("grant_unexpected", CW'(gnt), CW'(0));
        else begin
          eg = exp_gnt.pop_front();
          chk("grant_id", CW'(gnt), CW'(eg ? 2'b10 : 2'b01));
          chk("ld_ready_at_grant", CW'(ld_ready), CW'(1));
        end
      end
      if (ld_ready) ldc++;
      if (wr_ena != 3'b000) begin
        chk("wr_ena", CW'(wr_ena), CW'(3'b111));
        if (exp_wr.size() == 0) chk("wr_unexpected", CW'(wr_addr), CW'(0) - CW'(1));
        else begin
          ew = exp_wr.pop_front();
          chk("wr_addr", CW'(wr_addr), CW'(ew.addr));
          chk("wr_data", {wr_x, wr_y, wr_m, wr_m1}, ew.d);
        end
      end
      if (task_req) begin
        treq_n++;
        treq_total++;
        treq_cyc = cyc_n;
      end
      if (res_valid) begin
        if (!in_res) first_cyc = cyc_n;
        in_res = 1'b1;
        if (exp_res.size() == 0) chk("res_unexpected", CW'(res_data), CW'(0) - CW'(1));
        else begin
          er = exp_res.pop_front();
          chk("res_data", CW'(res_data), CW'(er.data));
          chk("res_id",   CW'(res_id),   CW'(er.id));
          chk("res_last", CW'(res_last), CW'(er.last));
          chk("res_err",  CW'(res_err),  CW'(er.err));
        end
        if (res_last) begin
          chk("gnt_clear", CW'(gnt), CW'(0));
          if (exp_job.size() != 0) begin
            ej = exp_job.pop_front();
            chk("load_cycles", CW'(ldc), CW'(ej.load_cyc));
            chk("task_req_pulses", CW'(treq_n), CW'(1));
            if (ej.silent) chk("timeout_latency", CW'(cyc_n - treq_cyc), CW'(ej.span));
            else           chk("burst_span", CW'(cyc_n - first_cyc + 1), CW'(ej.span));
          end
          ldc    = 0;
          treq_n = 0;
          in_res = 1'b0;
        end
      end
      gnt_prev = gnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rq[i] = 1'b0; lv[i] = 1'b0; lx[i] = '0; ly[i] = '0; lm[i] = '0; lm1[i] = '0;
    end
    mlast = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_gnt",       CW'(gnt),       CW'(0));
    chk("reset_ld_ready",  CW'(ld_ready),  CW'(0));
    chk("reset_wr_ena",    CW'(wr_ena),    CW'(0));
    chk("reset_task_req",  CW'(task_req),  CW'(0));
    chk("reset_res_valid", CW'(res_valid), CW'(0));
    chk("reset_res_data",  CW'(res_data),  CW'(0));
    chk("reset_res_err",   CW'(res_err),   CW'(0));
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    scen(2'b11, 1'b0, 1'b0, 1'b0, 0);   // first tie after reset
    scen(2'b11, 1'b0, 1'b0, 1'b0, 0);   // second tie
    scen(2'b01, 1'b0, 1'b0, 1'b0, 0);   // single back-to-back job
    scen(2'b10, 1'b0, 1'b1, 1'b0, 0);   // load gaps on requester 1
    scen(2'b11, 1'b0, 1'b0, 1'b1, 3);   // requester 1 noise while 0 owns the engine
    pause_at = 10; pause_len = 3;
    scen(2'b01, 1'b0, 1'b0, 1'b0, 0);   // engine pause mid-burst
    pause_at = -1; pause_len = 0;

    for (int r = 0; r < 6; r++) begin
      logic [1:0] m;
      m = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        pause_at  = int'($urandom_range(0, N - 2));
        pause_len = int'($urandom_range(1, 4));
      end else begin
        pause_at  = -1;
        pause_len = 0;
      end
      scen(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 0);
    end
    pause_at = -1; pause_len = 0;

`ifdef IDDMM_ARB_TIMEOUT_EN
    silent = 1'b1;
    scen(2'b01, 1'b0, 1'b0, 1'b0, 0);   // silent engine -> watchdog abort
    silent = 1'b0;
    scen(2'b10, 1'b0, 1'b0, 1'b0, 0);   // next job served normally
`endif

    chk("gnt_protocol", CW'(gnt_bad), CW'(0));
    chk("task_req_total", CW'(treq_total), CW'(jobs));
    chk("final_gnt", CW'(gnt), CW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
